vjtag_cmd_capture: RTL and testbench
====================================

# vjtag_cmd_capture

Upstream command front-end for the main trigger state machine. Takes the raw virtual-JTAG control outputs (`uir`, `udr`, `ir_in`, shift register contents), which are asynchronous to `clk`, and synchronises them into `clk`. It decodes each instruction and data update into a command record and queues it in a small FIFO. The trigger state machine pops records through a valid/ready handshake instead of comparing requested/done counters across clock domains.

## Interface
- `DATA_W`, 32, width of DR payload and `cmd_data`
- `FIFO_DEPTH`, 4, command FIFO entries; power of 2, at least 2
- `SYNC_STAGES`, 2, flops in each `uir`/`udr` synchroniser; at least 2
- `clk`  in  1  system clock (50 MHz); all logic on its rising edge
- `notReset`  in  1  asynchronous, active-low reset
- `uir`  in  1  vJTAG update-IR; async; `ir_in` is stable while high
- `udr`  in  1  vJTAG update-DR; async; `shift_data` is stable for at least 8 `clk` after its rise
- `ir_in`  in  4  current vJTAG instruction; async
- `shift_data`  in  DATA_W  vJTAG shift buffer; async
- `cmd_valid`  out  1  FIFO head valid
- `cmd_ready`  in  1  consumer accepts head this cycle
- `cmd_opcode`  out  4  head opcode
- `cmd_data`  out  DATA_W  head payload; 0 for IR-class records
- `cmd_count`  out  4  accepted-push counter, wraps 15→0; drives the 7-seg digit
- `overflow`  out  1  sticky: an event was lost
- `sys_reset_n`  out  1  soft reset to downstream logic; 0 after RESETLO, 1 after RESETHI

## Operation
- **Synchronisers:** `uir` and `udr` each pass through `SYNC_STAGES` flops that reset to 1. A level already high at reset release is therefore not an edge. A rising edge on the last stage sets `ir_pend` or `dr_pend`.
- **Buses:** `ir_in` and `shift_data` are never synchronised per bit. They are sampled once in CAPTURE only.
- **FSM states:** IDLE, SETTLE, CAPTURE, PUSH.
  - IDLE: if `ir_pend`, select IR and go to SETTLE. Otherwise, if `dr_pend`, select DR and go to SETTLE. IR wins when both are pending.
  - SETTLE: 2-cycle counter, then CAPTURE.
  - CAPTURE: register `ir_in` (IR) or `shift_data` (DR), clear the serviced pending flag, go to PUSH.
  - PUSH: act on the record per the classification below, then return to IDLE.
- **Opcode classes:**
  - 0x0 (post-instruction bypass) and 0xF: ignored. Nothing is pushed, but `cur_op` is updated.
  - 0xB RESETHI: `sys_reset_n`←1, FIFO untouched.
  - 0xC RESETLO: `sys_reset_n`←0, FIFO flushed, `cmd_count`←0.
  - IR class (0x1, 0x2, 0x4, 0x5, 0x8, 0xD, 0xE): on an IR event, push {op, 0}.
  - DR class (0x3, 0x6, 0x7, 0x9, 0xA): an IR event only updates `cur_op`. A DR event pushes {`cur_op`, `shift_data`}.
  - A DR event while `cur_op` is not DR class is discarded silently.
- **FIFO:**
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the record is dropped and `overflow`←1.
  - Pop happens when `cmd_valid` and `cmd_ready` are both high.
  - When empty, `cmd_valid`=0 and `cmd_opcode`/`cmd_data` hold their last values.
- **Missed events:** a new edge arriving while its pending flag is already set also sets `overflow`. `overflow` clears only on `notReset`.

## Timing
- **Reset values:** `cmd_valid` 0, `cmd_opcode` 0, `cmd_data` 0, `cmd_count` 0, `overflow` 0, `sys_reset_n` 1, `cur_op` 0, FIFO empty, FSM in IDLE, pending flags 0.
- **Latency:** pending flag set at cycle E, so SETTLE runs E+1..E+2, CAPTURE at E+3, PUSH at E+4.
  - FIFO write, `cmd_count` and `sys_reset_n` update at the end of E+4.
  - `cmd_valid` rises at E+5 when the FIFO was empty.
- **Handshake:** the head is stable while `cmd_valid` is high and `cmd_ready` is low. A pop at cycle T exposes the next entry at T+1.
- **Throughput:** at most one event per 5 cycles; events arriving faster are held by the pending flags.
- **Reset mid-operation:** asynchronous clear of everything above, including a record in PUSH.

## Configuration
- `VJTAG_CMD_DEDUP_EN` defined: an IR event whose opcode equals the last IR-event opcode is dropped. The 0x0 and 0xF events do not update that last-IR-event record.
- `VJTAG_CMD_DEDUP_EN` undefined: every IR event is classified and pushed.

## Test plan
- **Reset glitch check:** `notReset` low with `uir`=1, release → no push; `cmd_valid`=0, `sys_reset_n`=1 for 100 cycles.
- **IR then DR:** IR 0x7, then DR with `shift_data`=0xDEADBEEF → one record {0x7, 0xDEADBEEF}; `cmd_valid` high at E+5; `cmd_count`=1.
- **Reset opcodes:** 2 RUNTEST (0x4) records queued, then IR 0xC → FIFO empty, `cmd_count`=0, `sys_reset_n`=0. Then IR 0xB → `sys_reset_n`=1.
- **Overflow:** `cmd_ready`=0, 5 IR 0x4 events (each separated by IR 0x0) → 4 entries, `overflow`=1. Pop all four → opcode 0x4 ×4, then `cmd_valid`=0.
- **Simultaneous edges:** `uir` and `udr` rise together with `ir_in`=0x9 → IR serviced first, then the DR push {0x9, data} follows 5 cycles later.
- **Dedup:** IR 0x4, 0x0, 0x4 → 1 record with `VJTAG_CMD_DEDUP_EN` defined, 2 records without it.

Source files
------------

// File: rtl/vjtag_cmd_capture.sv
// vJTAG command front-end: synchronises uir/udr, decodes records, queues them.
// Optional: VJTAG_CMD_DEDUP_EN drops an IR event repeating the last IR opcode.
module vjtag_cmd_capture #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              notReset,
  input  logic              uir,
  input  logic              udr,
  input  logic [3:0]        ir_in,
  input  logic [DATA_W-1:0] shift_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [3:0]        cmd_opcode,
  output logic [DATA_W-1:0] cmd_data,
  output logic [3:0]        cmd_count,
  output logic              overflow,
  output logic              sys_reset_n
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_PUSH
  } state_e;

  function automatic logic is_ir_cls(input logic [3:0] op);
    return op inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'hD, 4'hE};
  endfunction

  function automatic logic is_dr_cls(input logic [3:0] op);
    return op inside {4'h3, 4'h6, 4'h7, 4'h9, 4'hA};
  endfunction

  logic [SYNC_STAGES-1:0] uir_s_q, udr_s_q;
  logic                   uir_l_q, udr_l_q;
  logic                   uir_rise, udr_rise;

  state_e            state_q;
  logic              sel_dr_q;
  logic              settle_q;
  logic [DATA_W-1:0] cap_q;
  logic              ir_pend_q, dr_pend_q;
  logic [3:0]        cur_op_q;
  logic              ovf_q;
  logic              srn_q;
`ifdef VJTAG_CMD_DEDUP_EN
  logic [3:0]        last_ir_q;
`endif

  logic [AW:0]       wr_q, rd_q;
  logic [3:0]        cnt_q;
  logic [3:0]        hold_op_q;
  logic [DATA_W-1:0] hold_data_q;
  logic [3:0]        op_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  logic              push_req, push_ok, drop, pop;
  logic              flush, rst_lo, rst_hi, dup;
  logic              full, empty;
  logic [3:0]        push_op;
  logic [DATA_W-1:0] push_data;
  logic              ir_clr, dr_clr, miss;

  // Sync flops reset high so a level already high at release is no edge
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      uir_s_q <= '1;
      udr_s_q <= '1;
      uir_l_q <= 1'b1;
      udr_l_q <= 1'b1;
    end else begin
      uir_s_q <= {uir_s_q[SYNC_STAGES-2:0], uir};
      udr_s_q <= {udr_s_q[SYNC_STAGES-2:0], udr};
      uir_l_q <= uir_s_q[SYNC_STAGES-1];
      udr_l_q <= udr_s_q[SYNC_STAGES-1];
    end
  end

  assign uir_rise = uir_s_q[SYNC_STAGES-1] & ~uir_l_q;
  assign udr_rise = udr_s_q[SYNC_STAGES-1] & ~udr_l_q;

  assign ir_clr = (state_q == S_CAPTURE) & ~sel_dr_q;
  assign dr_clr = (state_q == S_CAPTURE) & sel_dr_q;
  assign miss   = (uir_rise & ir_pend_q & ~ir_clr)
                | (udr_rise & dr_pend_q & ~dr_clr);

  always_comb begin
    push_req = 1'b0;
    flush    = 1'b0;
    rst_lo   = 1'b0;
    rst_hi   = 1'b0;
    dup      = 1'b0;
`ifdef VJTAG_CMD_DEDUP_EN
    dup      = ~sel_dr_q && (cap_q[3:0] == last_ir_q);
`endif
    if (state_q == S_PUSH) begin
      if (sel_dr_q) begin
        push_req = is_dr_cls(cur_op_q);
      end else if (!dup) begin
        unique case (1'b1)
          cap_q[3:0] == 4'hB:    rst_hi = 1'b1;
          cap_q[3:0] == 4'hC:    begin
            rst_lo = 1'b1;
            flush  = 1'b1;
          end
          is_ir_cls(cap_q[3:0]): push_req = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign push_op   = sel_dr_q ? cur_op_q : cap_q[3:0];
  assign push_data = sel_dr_q ? cap_q : '0;

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_q   <= S_IDLE;
      sel_dr_q  <= 1'b0;
      settle_q  <= 1'b0;
      cap_q     <= '0;
      ir_pend_q <= 1'b0;
      dr_pend_q <= 1'b0;
      cur_op_q  <= 4'h0;
      ovf_q     <= 1'b0;
      srn_q     <= 1'b1;
`ifdef VJTAG_CMD_DEDUP_EN
      last_ir_q <= 4'h0;
`endif
    end else begin
      ir_pend_q <= uir_rise | (ir_pend_q & ~ir_clr);
      dr_pend_q <= udr_rise | (dr_pend_q & ~dr_clr);
      ovf_q     <= ovf_q | miss | drop;
      case (state_q)
        S_IDLE: begin
          settle_q <= 1'b0;
          if (ir_pend_q) begin
            sel_dr_q <= 1'b0;
            state_q  <= S_SETTLE;
          end else if (dr_pend_q) begin
            sel_dr_q <= 1'b1;
            state_q  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          settle_q <= 1'b1;
          if (settle_q) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          cap_q   <= sel_dr_q ? shift_data
                              : {{(DATA_W-4){1'b0}}, ir_in};
          state_q <= S_PUSH;
        end
        S_PUSH: begin
          if (!sel_dr_q) begin
            cur_op_q <= cap_q[3:0];
`ifdef VJTAG_CMD_DEDUP_EN
            if (cap_q[3:0] != 4'h0 && cap_q[3:0] != 4'hF)
              last_ir_q <= cap_q[3:0];
`endif
          end
          if (rst_lo) srn_q <= 1'b0;
          if (rst_hi) srn_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW])
                 && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = ~empty & cmd_ready;
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & ~push_ok;

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= 4'h0;
      hold_op_q   <= 4'h0;
      hold_data_q <= '0;
    end else begin
      if (!empty) begin
        hold_op_q   <= op_mem[rd_q[AW-1:0]];
        hold_data_q <= data_mem[rd_q[AW-1:0]];
      end
      if (flush) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= 4'h0;
      end else begin
        if (push_ok) begin
          wr_q  <= wr_q + 1'b1;
          cnt_q <= cnt_q + 4'd1;
        end
        if (pop) rd_q <= rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      op_mem[wr_q[AW-1:0]]   <= push_op;
      data_mem[wr_q[AW-1:0]] <= push_data;
    end
  end

  assign cmd_valid   = ~empty;
  assign cmd_opcode  = empty ? hold_op_q : op_mem[rd_q[AW-1:0]];
  assign cmd_data    = empty ? hold_data_q : data_mem[rd_q[AW-1:0]];
  assign cmd_count   = cnt_q;
  assign overflow    = ovf_q;
  assign sys_reset_n = srn_q;

endmodule

// File: tb/tb_vjtag_cmd_capture.sv
// Scoreboard bench for vjtag_cmd_capture against a queue-based reference model.
// Honours VJTAG_CMD_DEDUP_EN the same way the design does.
module tb_vjtag_cmd_capture;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          notReset = 1'b0;
  logic          uir = 1'b0;
  logic          udr = 1'b0;
  logic [3:0]    ir_in = 4'h0;
  logic [DW-1:0] shift_data = '0;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [3:0]    cmd_opcode;
  logic [DW-1:0] cmd_data;
  logic [3:0]    cmd_count;
  logic          overflow;
  logic          sys_reset_n;

  vjtag_cmd_capture #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .notReset(notReset), .uir(uir), .udr(udr),
    .ir_in(ir_in), .shift_data(shift_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_data(cmd_data),
    .cmd_count(cmd_count), .overflow(overflow),
    .sys_reset_n(sys_reset_n)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] d;
  } rec_t;

  rec_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] m_cur = 4'h0;
  logic [3:0] m_last = 4'h0;
  logic [3:0] m_cnt = 4'h0;
  logic       m_srn = 1'b1;
  logic       m_ovf = 1'b0;
  bit         rand_ready = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit ir_cls(input logic [3:0] op);
    return op inside {1, 2, 4, 5, 8, 13, 14};
  endfunction

  function automatic bit dr_cls(input logic [3:0] op);
    return op inside {3, 6, 7, 9, 10};
  endfunction

  task automatic m_push(input logic [3:0] op, input logic [DW-1:0] d);
    rec_t r;
    if (exp_q.size() < DEPTH) begin
      r.op = op;
      r.d  = d;
      exp_q.push_back(r);
      m_cnt = m_cnt + 4'd1;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_ir(input logic [3:0] op);
    m_cur = op;
    if (op == 4'h0 || op == 4'hF) return;
`ifdef VJTAG_CMD_DEDUP_EN
    if (op == m_last) return;
    m_last = op;
`endif
    if (op == 4'hB) m_srn = 1'b1;
    else if (op == 4'hC) begin
      m_srn = 1'b0;
      exp_q.delete();
      m_cnt = 4'h0;
    end else if (ir_cls(op)) m_push(op, '0);
  endtask

  task automatic model_dr(input logic [DW-1:0] d);
    if (dr_cls(m_cur)) m_push(m_cur, d);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, cmd_count, m_cnt);
    chk({tag, "_srn"}, sys_reset_n, m_srn);
    chk({tag, "_ovf"}, overflow, m_ovf);
  endtask

  task automatic ir_ev(input logic [3:0] op);
    @(negedge clk);
    ir_in = op;
    uir   = 1'b1;
    model_ir(op);
    repeat (10) @(negedge clk);
    uir = 1'b0;
    repeat (4) @(negedge clk);
    chk_state("ir");
  endtask

  task automatic dr_ev(input logic [DW-1:0] d);
    @(negedge clk);
    shift_data = d;
    udr        = 1'b1;
    model_dr(d);
    repeat (10) @(negedge clk);
    udr = 1'b0;
    repeat (4) @(negedge clk);
    chk_state("dr");
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("drain_valid", cmd_valid, 1'b0);
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #2;
      cmd_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every DUT pop is matched against the scoreboard head
  always @(negedge clk) begin
    if (notReset && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      rec_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got op %h data %h expected none",
                 cmd_opcode, cmd_data);
      end else begin
        e = exp_q.pop_front();
        chk("pop_op", cmd_opcode, e.op);
        chk("pop_data", cmd_data, e.d);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit saw_v;
    bit saw_lo;
    logic [3:0] op;

    uir   = 1'b1;
    ir_in = 4'h4;
    repeat (3) @(negedge clk);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_opcode", cmd_opcode, 4'h0);
    chk("rst_data", cmd_data, '0);
    chk("rst_count", cmd_count, 4'h0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_srn", sys_reset_n, 1'b1);
    notReset = 1'b1;
    saw_v  = 1'b0;
    saw_lo = 1'b0;
    repeat (100) begin
      @(negedge clk);
      saw_v  = saw_v | cmd_valid;
      saw_lo = saw_lo | ~sys_reset_n;
    end
    chk("glitch_valid", saw_v, 1'b0);
    chk("glitch_srn_lo", saw_lo, 1'b0);
    chk("glitch_count", cmd_count, 4'h0);
    uir = 1'b0;
    repeat (5) @(negedge clk);

    ir_ev(4'h7);
    @(negedge clk);
    shift_data = 32'hDEADBEEF;
    udr        = 1'b1;
    model_dr(32'hDEADBEEF);
    n = 0;
    while (!cmd_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("dr_latency_ok", (n >= 7 && n <= 8), 1'b1);
    chk("head_op", cmd_opcode, 4'h7);
    chk("head_data", cmd_data, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("head_stable", cmd_data, 32'hDEADBEEF);
    udr = 1'b0;
    repeat (4) @(negedge clk);
    chk_state("irdr");
    cmd_ready = 1'b1;
    drain();
    chk("empty_hold_op", cmd_opcode, 4'h7);
    cmd_ready = 1'b0;

    ir_ev(4'h4);
    ir_ev(4'h0);
    ir_ev(4'h4);
    ir_ev(4'hC);
    chk("lo_valid", cmd_valid, 1'b0);
    ir_ev(4'hB);

    for (int i = 0; i < 5; i++) begin
      ir_ev(4'h4);
      ir_ev(4'h0);
    end
    chk("ovf_valid", cmd_valid, (exp_q.size() != 0));
    cmd_ready = 1'b1;
    drain();

    ir_ev(4'h4);
    ir_ev(4'h0);
    ir_ev(4'h4);
    drain();

    @(negedge clk);
    ir_in      = 4'h9;
    shift_data = 32'h1234_5678;
    uir        = 1'b1;
    udr        = 1'b1;
    model_ir(4'h9);
    model_dr(32'h1234_5678);
    repeat (12) @(negedge clk);
    uir = 1'b0;
    udr = 1'b0;
    repeat (10) @(negedge clk);
    chk_state("simul");
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (exp_q.size() >= DEPTH && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) chk("rand_wait", exp_q.size(), DEPTH - 1);
      if ($urandom_range(0, 1) == 1) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hC) op = 4'hB;
        ir_ev(op);
      end else begin
        dr_ev($urandom);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #5 cmd_ready = 1'b1;
    drain();

    @(negedge clk);
    notReset = 1'b0;
    #1;
    chk("async_ovf", overflow, 1'b0);
    chk("async_count", cmd_count, 4'h0);
    chk("async_srn", sys_reset_n, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
